// File: rtl/updi_pkg.sv
// Shared UPDI types and default widths for the break generator and related timing blocks.
package updi_pkg;

  localparam int UPDI_CNT_W  = 17;
  localparam int UPDI_NBRK_W = 4;

  typedef enum logic [1:0] {
    BRK_IDLE = 2'd0,
    BRK_LOW  = 2'd1,
    BRK_HIGH = 2'd2
  } brk_state_t;

endpackage

// File: rtl/updi_down_counter.sv
// Loadable down counter with a zero flag; holds at zero until reloaded.
module updi_down_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= value;
    end else if (en && (count != {W{1'b0}})) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/updi_break_gen.sv
// Programmable UPDI BREAK generator: N low pulses of L clocks, each followed by an H-clock high gap.
module updi_break_gen
  import updi_pkg::*;
#(
  parameter int CNT_W  = UPDI_CNT_W,
  parameter int NBRK_W = UPDI_NBRK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NBRK_W-1:0] n_breaks,
  input  logic [CNT_W-1:0]  low_clks,
  input  logic [CNT_W-1:0]  high_clks,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [NBRK_W-1:0] brk_idx,
  output logic              pulse,
  output logic              tx_oe
);

  brk_state_t        state;
  logic [CNT_W-1:0]  lo_m1;
  logic [CNT_W-1:0]  hi_m1;
  logic [NBRK_W-1:0] n_last;
  logic [CNT_W-1:0]  lo_in_m1;
  logic [CNT_W-1:0]  hi_in_m1;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_en;
  logic              cnt_zero;
  logic              more;

  // A zero length behaves as one clock, so the reload value is max(len,1)-1.
  assign lo_in_m1 = (low_clks  == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : low_clks  - CNT_W'(1);
  assign hi_in_m1 = (high_clks == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : high_clks - CNT_W'(1);
  assign more     = (brk_idx < n_last);

  // Phase counter control: reload at each phase boundary, otherwise count down.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = {CNT_W{1'b0}};
    cnt_en    = 1'b0;
    case (state)
      BRK_IDLE: begin
        if (start && (n_breaks != {NBRK_W{1'b0}})) begin
          cnt_load  = 1'b1;
          cnt_value = lo_in_m1;
        end else begin
          cnt_load  = 1'b0;
        end
      end
      BRK_LOW: begin
        if (!abort && cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_value = hi_m1;
        end else begin
          cnt_en    = 1'b1;
        end
      end
      BRK_HIGH: begin
        if (!abort && cnt_zero && more) begin
          cnt_load  = 1'b1;
          cnt_value = lo_m1;
        end else begin
          cnt_en    = 1'b1;
        end
      end
      default: begin
        cnt_en = 1'b0;
      end
    endcase
  end

  updi_down_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .en    (cnt_en),
    .zero  (cnt_zero)
  );

  // Sequencer FSM with registered status and one-cycle strobes; abort beats any phase end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BRK_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      brk_idx <= {NBRK_W{1'b0}};
      lo_m1   <= {CNT_W{1'b0}};
      hi_m1   <= {CNT_W{1'b0}};
      n_last  <= {NBRK_W{1'b0}};
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        BRK_IDLE: begin
          if (start) begin
            lo_m1   <= lo_in_m1;
            hi_m1   <= hi_in_m1;
            n_last  <= n_breaks - NBRK_W'(1);
            brk_idx <= {NBRK_W{1'b0}};
            if (n_breaks == {NBRK_W{1'b0}}) begin
              done <= 1'b1;
            end else begin
              state <= BRK_LOW;
              busy  <= 1'b1;
            end
          end
        end
        BRK_LOW: begin
          if (abort) begin
            state   <= BRK_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
            brk_idx <= {NBRK_W{1'b0}};
          end else if (cnt_zero) begin
            state <= BRK_HIGH;
          end
        end
        BRK_HIGH: begin
          if (abort) begin
            state   <= BRK_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
            brk_idx <= {NBRK_W{1'b0}};
          end else if (cnt_zero) begin
            if (more) begin
              state   <= BRK_LOW;
              brk_idx <= brk_idx + NBRK_W'(1);
            end else begin
              state   <= BRK_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              brk_idx <= {NBRK_W{1'b0}};
            end
          end
        end
        default: begin
          state   <= BRK_IDLE;
          busy    <= 1'b0;
          brk_idx <= {NBRK_W{1'b0}};
        end
      endcase
    end
  end

  assign pulse = (state != BRK_LOW);
  assign tx_oe = busy;

endmodule

// File: tb/tb_updi_break_gen.sv
// Directed self-checking bench for updi_break_gen; cycle c = c-th clock after the start-accept edge.
module tb_updi_break_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  n_breaks;
  logic [16:0] low_clks;
  logic [16:0] high_clks;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [3:0]  brk_idx;
  logic        pulse;
  logic        tx_oe;

  int n_tests = 0;
  int n_fail  = 0;

  updi_break_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_breaks  (n_breaks),
    .low_clks  (low_clks),
    .high_clks (high_clks),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .brk_idx   (brk_idx),
    .pulse     (pulse),
    .tx_oe     (tx_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string t, input int c, input bit e_busy, input bit e_pulse,
                             input bit e_done, input bit e_abt, input int e_idx);
    check($sformatf("%s_c%0d_busy", t, c),    32'(busy),    32'(e_busy));
    check($sformatf("%s_c%0d_tx_oe", t, c),   32'(tx_oe),   32'(e_busy));
    check($sformatf("%s_c%0d_pulse", t, c),   32'(pulse),   32'(e_pulse));
    check($sformatf("%s_c%0d_done", t, c),    32'(done),    32'(e_done));
    check($sformatf("%s_c%0d_aborted", t, c), 32'(aborted), 32'(e_abt));
    check($sformatf("%s_c%0d_brk_idx", t, c), 32'(brk_idx), 32'(e_idx));
  endtask

  // Present start (optionally with abort) for one accept edge; returns in cycle 1.
  task automatic launch(input int n, input int lo, input int hi, input bit with_abort);
    n_breaks  = 4'(n);
    low_clks  = 17'(lo);
    high_clks = 17'(hi);
    start     = 1'b1;
    abort     = with_abort;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    n_breaks  = 4'd9;
    low_clks  = 17'd99;
    high_clks = 17'd99;
  endtask

  // Case 1 reference (N=2, L=5, H=3) expectations.
  function automatic bit c1_low(input int c);
    return ((c >= 1) && (c <= 5)) || ((c >= 9) && (c <= 13));
  endfunction
  function automatic int c1_idx(input int c);
    return ((c >= 9) && (c <= 16)) ? 1 : 0;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    n_breaks = 4'd0; low_clks = 17'd0; high_clks = 17'd0;
    tick(); tick();
    check_cycle("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    rst = 1'b0;
    tick();

    // 1: double break N=2 L=5 H=3
    launch(2, 5, 3, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      check_cycle("t1", c, c <= 16, !c1_low(c), c == 17, 1'b0, c1_idx(c));
      tick();
    end

    // 2: zero lengths treated as one
    launch(1, 0, 0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      check_cycle("t2", c, c <= 2, c != 1, c == 3, 1'b0, 0);
      tick();
    end

    // 3: N=0 gives immediate done, no activity
    launch(0, 7, 7, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      check_cycle("t3", c, 1'b0, 1'b1, c == 1, 1'b0, 0);
      tick();
    end

    // 4: N=3 L=4 H=4, abort on cycle 10
    launch(3, 4, 4, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      if (c <= 10)
        check_cycle("t4", c, 1'b1, !((c <= 4) || (c >= 9)), 1'b0, 1'b0, (c >= 9) ? 1 : 0);
      else
        check_cycle("t4", c, 1'b0, 1'b1, 1'b0, c == 11, 0);
      abort = (c == 10);
      tick();
    end
    abort = 1'b0;

    // 5: start re-pulsed on cycle 4 is ignored; rst on cycle 7 releases the line
    launch(2, 5, 3, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 7)
        check_cycle("t5", c, 1'b1, !c1_low(c), 1'b0, 1'b0, c1_idx(c));
      else
        check_cycle("t5", c, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      start    = (c == 4);
      n_breaks = 4'd1;
      low_clks = 17'd1;
      rst      = (c == 7);
      tick();
    end
    start = 1'b0;
    rst   = 1'b0;

    // 6a: abort coinciding with the final HIGH end wins over done
    launch(2, 5, 3, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16)
        check_cycle("t6a", c, 1'b1, !c1_low(c), 1'b0, 1'b0, c1_idx(c));
      else
        check_cycle("t6a", c, 1'b0, 1'b1, 1'b0, c == 17, 0);
      abort = (c == 16);
      tick();
    end
    abort = 1'b0;

    // 6b: start on the done cycle is accepted immediately
    launch(1, 2, 1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      check_cycle("t6b", c, (c <= 3) || (c == 5) || (c == 6),
                  !((c <= 2) || (c == 5)), (c == 4) || (c == 7), 1'b0, 0);
      start     = (c == 4);
      n_breaks  = 4'd1;
      low_clks  = 17'd1;
      high_clks = 17'd1;
      tick();
    end
    start = 1'b0;

    // 7: abort together with start in IDLE is ignored, start accepted
    launch(1, 1, 1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      check_cycle("t7", c, c <= 2, c != 1, c == 3, 1'b0, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
